// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep controller and
// the gate-characterisation conventions it shares.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } tt_state_e;

  localparam int TT_ROWS = 8;

  // Row 3'b000 lives in the table MSB, row 3'b111 in the LSB.
  function automatic logic [2:0] tt_bit_idx(input logic [2:0] row);
    return 3'd7 - row;
  endfunction

endpackage

// File: rtl/tt_sample_vote.sv
// Majority voter: counts ones on din while en is high, vote reflects the
// majority including the din value present at the current edge.
module tt_sample_vote #(
  parameter int SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic din,
  output logic vote
);

  logic [2:0] ones;
  logic [3:0] total;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ones <= '0;
    end else if (en && din) begin
      ones <= ones + 3'd1;
    end
  end

  // The last sample is folded in here so the row bit lands on its own edge.
  assign total = {1'b0, ones} + {3'b000, din};
  assign vote  = total > 4'(SAMPLES / 2);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all eight rows of a 3-input gate, majority-samples its output per
// row and reports the measured table, mismatch mask and pass/fail.
module tt_sweep_ctrl
  import tt_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE   = 8'h9B,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         SAMPLES       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       dut_out,
  output logic [7:0] measured,
  output logic [7:0] mismatch,
  output logic       pass
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] SAMPLE_LAST = 3'(SAMPLES - 1);
  localparam logic [2:0] ROW_LAST    = 3'(TT_ROWS - 1);

  tt_state_e  state, state_next;
  logic [7:0] settle_cnt;
  logic [2:0] sample_cnt;
  logic [2:0] row;
  logic       vote;
  logic       row_done;
  logic [7:0] meas_next;

  tt_sample_vote #(
    .SAMPLES(SAMPLES)
  ) u_vote (
    .clk  (clk),
    .rst  (rst),
    .clear(state != SAMPLE),
    .en   (state == SAMPLE),
    .din  (dut_out),
    .vote (vote)
  );

  // NOTE: defaults first keep this block latch-free on every path.
  always_comb begin
    state_next = state;
    row_done   = 1'b0;
    meas_next  = measured;
    case (state)
      IDLE:   if (start) state_next = SETTLE;
      SETTLE: if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
      SAMPLE: begin
        if (sample_cnt == SAMPLE_LAST) begin
          row_done   = 1'b1;
          state_next = (row == ROW_LAST) ? DONE : SETTLE;
          meas_next[tt_bit_idx(row)] = vote;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      sample_cnt <= '0;
      row        <= '0;
      measured   <= '0;
      mismatch   <= '0;
      pass       <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= (state == SETTLE && state_next == SETTLE) ? settle_cnt + 8'd1 : '0;
      sample_cnt <= (state == SAMPLE && state_next == SAMPLE) ? sample_cnt + 3'd1 : '0;
      if (state == IDLE && start) begin
        row      <= '0;
        measured <= '0;
      end else if (row_done) begin
        measured <= meas_next;
        // Verdict is registered on the DONE-entry edge so it is valid with done.
        if (row == ROW_LAST) begin
          mismatch <= meas_next ^ TRUTH_TABLE;
          pass     <= (meas_next == TRUTH_TABLE);
        end else begin
          row <= row + 3'd1;
        end
      end
    end
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign {in1, in2, in3} = row;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: cycle-offset scoreboard plus directed sweeps with
// hand-computed tables, and a lagging-gate instance with one sample per row.
module tb_tt_sweep_ctrl;

  localparam int         S      = 4;
  localparam int         N      = 3;
  localparam int         W      = S + N;
  localparam int         DONE_K = 8 * W + 1;
  localparam logic [7:0] TT     = 8'h9B;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, in1, in2, in3;
  logic       dut_out = 1'b0;
  logic [7:0] measured, mismatch;
  logic       pass;

  logic       start2 = 1'b0;
  logic       busy2, done2, a1, a2, a3;
  logic       dut_out2 = 1'b0;
  logic [7:0] measured2, mismatch2;
  logic       pass2;
  logic [2:0] hist [5];

  int checks   = 0;
  int failures = 0;
  int mode     = 0;

  // Scoreboard state: sweep activity and cycle offset since the accepting edge.
  bit         mon_en   = 1'b0;
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [2:0] m_row    = 3'd0;
  logic [7:0] m_meas   = 8'h00;
  logic [7:0] m_mism   = 8'h00;
  logic       m_pass   = 1'b0;
  int         m_ones [8];

  always #5 clk = ~clk;

  tt_sweep_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in1(in1), .in2(in2), .in3(in3), .dut_out(dut_out),
    .measured(measured), .mismatch(mismatch), .pass(pass)
  );

  tt_sweep_ctrl #(.TRUTH_TABLE(8'h9B), .SETTLE_CYCLES(4), .SAMPLES(1)) u_dut_lag (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .in1(a1), .in2(a2), .in3(a3), .dut_out(dut_out2),
    .measured(measured2), .mismatch(mismatch2), .pass(pass2)
  );

  function automatic logic gate(input logic [2:0] r);
    logic [7:0] t;
    t = TT;
    return t[7 - int'(r)];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lagging gate: output reflects the inputs applied SETTLE_CYCLES+1 cycles ago.
  always @(posedge clk) begin
    hist[0] <= {a1, a2, a3};
    for (int i = 1; i < 5; i++) hist[i] <= hist[i-1];
  end

  // Gate model with optional stuck/flip faults, updated just after each edge.
  always @(posedge clk) begin : drv
    int   r, pos;
    logic flip;
    #1;
    flip = 1'b0;
    if (m_active && m_k < DONE_K) begin
      r   = (m_k - 1) / W;
      pos = (m_k - 1) % W - S;
      if (mode == 3 && pos >= 0 && pos == r % 3) flip = 1'b1;
      if (mode == 4 && r == 5 && (pos == 0 || pos == 1)) flip = 1'b1;
    end
    case (mode)
      1:       dut_out = 1'b0;
      2:       dut_out = 1'b1;
      default: dut_out = gate({in1, in2, in3}) ^ flip;
    endcase
    dut_out2 = gate(hist[4]);
  end

  // Compare on the falling edge, then advance the model across the next rising edge.
  always @(negedge clk) begin : mon
    int         r, pos;
    logic [2:0] exp_row;
    if (mon_en) begin
      if (m_active) exp_row = (m_k < DONE_K) ? 3'((m_k - 1) / W) : 3'd7;
      else          exp_row = m_row;
      check("busy", busy, m_active);
      check("done", done, m_active && m_k == DONE_K);
      check("row", {in1, in2, in3}, exp_row);
      check("measured", measured, m_meas);
      if (!m_active || m_k == DONE_K) begin
        check("mismatch", mismatch, m_mism);
        check("pass", pass, m_pass);
      end
      if (rst) begin
        m_active = 1'b0; m_k = 0; m_row = 3'd0;
        m_meas = 8'h00; m_mism = 8'h00; m_pass = 1'b0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1'b1; m_k = 1; m_row = 3'd0; m_meas = 8'h00;
          for (int i = 0; i < 8; i++) m_ones[i] = 0;
        end
      end else if (m_k == DONE_K) begin
        m_active = 1'b0;
        m_row    = 3'd7;
      end else begin
        r   = (m_k - 1) / W;
        pos = (m_k - 1) % W;
        if (pos >= S) m_ones[r] += int'(dut_out);
        if (pos == W - 1) m_meas[7 - r] = (2 * m_ones[r] > N);
        if (m_k == DONE_K - 1) begin
          m_mism = m_meas ^ TT;
          m_pass = (m_mism == 8'h00);
        end
        m_k++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one edge and return the cycle offset at which done appears.
  task automatic sweep(input int m, output int lat);
    mode = m;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      step(1);
      lat++;
    end
  endtask

  task automatic sweep_expect(input string name, input int m, input logic [7:0] meas,
                              input logic [7:0] mism, input logic ok);
    int lat;
    sweep(m, lat);
    check({name, "_latency"}, lat, 57);
    check({name, "_measured"}, measured, meas);
    check({name, "_mismatch"}, mismatch, mism);
    check({name, "_pass"}, pass, ok);
    step(1);
    check({name, "_busy_low"}, busy, 1'b0);
    check({name, "_hold"}, measured, meas);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat, c, nd, seen;
    int t [3];
    rst = 1'b1;
    step(3);
    mon_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_row", {in1, in2, in3}, 3'd0);
    check("rst_measured", measured, 8'h00);
    check("rst_mismatch", mismatch, 8'h00);
    check("rst_pass", pass, 1'b0);
    step(1);
    rst = 1'b0;
    step(2);

    sweep_expect("gate",    0, 8'h9B, 8'h00, 1'b1);
    sweep_expect("stuck0",  1, 8'h00, 8'h9B, 1'b0);
    sweep_expect("stuck1",  2, 8'hFF, 8'h64, 1'b0);
    sweep_expect("flip1",   3, 8'h9B, 8'h00, 1'b1);
    sweep_expect("flip2r5", 4, 8'h9F, 8'h04, 1'b0);

    // Abort mid-sweep: rst high during cycle T0+20.
    mode = 0;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(19);
    rst = 1'b1;
    step(1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_row", {in1, in2, in3}, 3'd0);
    check("abort_measured", measured, 8'h00);
    check("abort_mismatch", mismatch, 8'h00);
    check("abort_pass", pass, 1'b0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      step(1);
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);
    sweep_expect("after_abort", 0, 8'h9B, 8'h00, 1'b1);

    // start held high: sweeps chain back-to-back.
    step(1);
    start = 1'b1;
    step(1);
    c  = 1;
    nd = 0;
    while (nd < 3 && c < 400) begin
      if (done === 1'b1) begin
        t[nd] = c;
        nd++;
      end
      step(1);
      c++;
    end
    start = 1'b0;
    check("b2b_pulses", nd, 3);
    check("b2b_first", t[0], 57);
    check("b2b_period1", t[1] - t[0], 58);
    check("b2b_period2", t[2] - t[1], 58);
    step(3);
    check("b2b_idle", busy, 1'b0);

    // Lagging gate with one sample per row: rows differing from the previous row fail.
    step(1);
    start2 = 1'b1;
    step(1);
    start2 = 1'b0;
    lat = 1;
    while (done2 !== 1'b1 && lat < 200) begin
      step(1);
      lat++;
    end
    check("lag_latency", lat, 41);
    check("lag_measured", measured2, 8'hCD);
    check("lag_mismatch", mismatch2, 8'h56);
    check("lag_pass", pass2, 1'b0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that characterises a 3-input, 1-output logic gate (the 0x9B-style truth-table gates) by sweeping all eight input combinations, waiting a programmable settle time per row, majority-sampling the gate output and comparing it against an expected truth table. It sits between the test/configuration host and one gate instance. It owns the gate's `in1`/`in2`/`in3` drives and reports the measured table, a per-row mismatch mask and pass/fail.

## Interface
Parameters:
- `TRUTH_TABLE`, 8'h9B, expected table; MSB = row 3'b000, LSB = row 3'b111.
- `SETTLE_CYCLES`, 4, cycles a row is held before sampling starts (1..255).
- `SAMPLES`, 3, samples per row for majority vote (odd, 1..7).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  one-cycle pulse when results are valid.
- `in1`, `in2`, `in3`  out  1 each  gate input drives; `{in1,in2,in3}` = current row.
- `dut_out`  in  1  gate output.
- `measured`  out  8  measured table, same bit ordering as `TRUTH_TABLE`.
- `mismatch`  out  8  `measured ^ TRUTH_TABLE`, valid with/after `done`.
- `pass`  out  1  `mismatch == 0`, valid with/after `done`.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `start`=1 clears `measured`, sets row=0, goes to SETTLE.
- SETTLE: holds the row, counts SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: counts `dut_out` ones over SAMPLES consecutive cycles. Row bit = 1 iff ones > SAMPLES/2. The bit is written to `measured[7-row]`.
  - If row < 7: row+1 and back to SETTLE.
  - If row = 7: go to DONE.
- DONE: lasts one cycle, asserts `done`, updates `mismatch`/`pass`, then returns to IDLE.
- Results hold until the next accepted `start` or `rst`.
- `start` in SETTLE/SAMPLE/DONE is ignored; no queueing.
- Row counter is 3 bits; no wrap occurs because row 7 exits to DONE.
- Sample counter is 3 bits; settle counter is 8 bits.
- Inputs `in1..in3` change only on SETTLE entry. They are stable for the whole SETTLE+SAMPLE window of a row.
- Reset values: state IDLE, `busy`=0, `done`=0, `in1..in3`=0, `measured`=0, `mismatch`=0, `pass`=0.
- `rst` mid-sweep aborts in the same cycle and applies the reset values. No `done` is produced for an aborted sweep.

## Timing
- `start` accepted at edge T0.
- Row r inputs are driven from T0+1+r·(SETTLE_CYCLES+SAMPLES).
- `dut_out` is sampled on the last SAMPLES cycles of each row window.
- `done` is high in cycle T0+1+8·(SETTLE_CYCLES+SAMPLES). With defaults this is T0+57.
- `busy` falls in the cycle after `done`.
- A new `start` is accepted no earlier than the cycle after `done`. That gives a back-to-back sweep period of 8·(S+N)+2 cycles.
- `dut_out` is registered-sampled: the value present at the clock edge is counted. There is no combinational path from `dut_out` to any output.

## Structure
- Shared package `tt_pkg`:
  - state enum `tt_state_e` {IDLE, SETTLE, SAMPLE, DONE};
  - constant `TT_ROWS` = 8;
  - function `tt_bit_idx(row)` = 7-row, shared with the gate truth-table conventions.
- Sub-module `tt_sample_vote`:
  - ports: `clk`, `rst`, `clear`, `en`, `din`, `vote`;
  - function: accumulates ones, outputs the majority for SAMPLES.
- The controller contains the FSM, settle counter, row counter and result registers.

## Test plan
- Behavioural 0x9B gate model, defaults → `done` at T0+57, `measured`=8'h9B, `mismatch`=0, `pass`=1.
- `dut_out` stuck at 0 → `measured`=8'h00, `mismatch`=8'h9B, `pass`=0. Stuck at 1 → `measured`=8'hFF, `mismatch`=8'h64.
- Correct model with a forced flip on exactly one of the 3 samples of every row → majority masks it, `pass`=1. With 2 of 3 samples flipped on row 3'b101 → `mismatch`=8'h04.
- Settle violation: model output lags the input change by SETTLE_CYCLES+1 cycles. With SAMPLES=1 → every row whose value differs from the previous row mismatches, and `pass`=0.
- `rst` asserted at T0+20 → next cycle all outputs are at reset values and the state is IDLE. No `done` follows. A fresh `start` completes normally.
- `start` held high continuously → sweeps run back-to-back. `done` pulses every 58 cycles and the inputs re-sweep from 3'b000 each time.
